// File: rtl/pipe_stage_reg.sv
// Generic Y86-64 pipeline stage register. Each clock it loads the next instruction,
// holds it (stall) or inserts a nop (bubble), and keeps hazard-debug counters.
module pipe_stage_reg #(
  parameter int                DATA_W       = 144,
  parameter int                STAT_W       = 3,
  parameter logic [3:0]        BUBBLE_ICODE = 4'h1,
  parameter logic [STAT_W-1:0] BUBBLE_STAT  = STAT_W'(1),
  parameter bit                CLEAR_ON_BUB = 1'b1,
  parameter int                CNT_W        = 16,
  parameter int                STALL_LIMIT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              bubble,
  input  logic [STAT_W-1:0] in_stat,
  input  logic [3:0]        in_icode,
  input  logic [DATA_W-1:0] in_data,
  output logic [STAT_W-1:0] out_stat,
  output logic [3:0]        out_icode,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_run,
  output logic              wdog_trip,
  output logic              conflict
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(STALL_LIMIT);

  logic [CNT_W-1:0] stall_cnt_inc;
  logic [CNT_W-1:0] bubble_cnt_inc;
  logic [CNT_W-1:0] stall_run_inc;

  // NOTE: every always_comb output gets a value on every path (here via the
  // ternaries), so no latch can be inferred.
  always_comb begin
    stall_cnt_inc  = (stall_cnt  == CNT_MAX) ? stall_cnt  : stall_cnt  + CNT_W'(1);
    bubble_cnt_inc = (bubble_cnt == CNT_MAX) ? bubble_cnt : bubble_cnt + CNT_W'(1);
    stall_run_inc  = (stall_run  == CNT_MAX) ? stall_run  : stall_run  + CNT_W'(1);
  end

  // NOTE: state is written only with non-blocking assignments, so every branch
  // sees the pre-edge values of the counters it reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Tested first so X on stall/bubble during reset cannot reach any flop.
      out_stat   <= BUBBLE_STAT;
      out_icode  <= BUBBLE_ICODE;
      out_data   <= '0;
      out_valid  <= 1'b0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      stall_run  <= '0;
      wdog_trip  <= 1'b0;
      conflict   <= 1'b0;
    end else if (stall) begin
      stall_cnt <= stall_cnt_inc;
      stall_run <= stall_run_inc;
      if (stall_run_inc == LIMIT_VAL) wdog_trip <= 1'b1;
      if (bubble) conflict <= 1'b1;
    end else if (bubble) begin
      out_stat   <= BUBBLE_STAT;
      out_icode  <= BUBBLE_ICODE;
      out_valid  <= 1'b0;
      if (CLEAR_ON_BUB) out_data <= '0;
      bubble_cnt <= bubble_cnt_inc;
      stall_run  <= '0;
    end else begin
      out_stat  <= in_stat;
      out_icode <= in_icode;
      out_data  <= in_data;
      out_valid <= 1'b1;
      stall_run <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a vector table for load/stall/bubble plus
// hand sequences for the watchdog, conflict flag and counter saturation.
module tb_pipe_stage_reg;

  logic         clk = 1'b0;
  logic         reset, stall, bubble;
  logic [2:0]   in_stat, out_stat;
  logic [3:0]   in_icode, out_icode;
  logic [143:0] in_data, out_data;
  logic         out_valid, wdog_trip, conflict;
  logic [15:0]  stall_cnt, bubble_cnt, stall_run;

  // Narrow instance used to reach counter saturation quickly.
  logic         s_reset, s_stall, s_bubble;
  logic [2:0]   s_in_stat, s_out_stat;
  logic [3:0]   s_in_icode, s_out_icode;
  logic [7:0]   s_in_data, s_out_data;
  logic         s_out_valid, s_wdog_trip, s_conflict;
  logic [2:0]   s_stall_cnt, s_bubble_cnt, s_stall_run;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_data(in_data),
    .out_stat(out_stat), .out_icode(out_icode), .out_data(out_data),
    .out_valid(out_valid), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .stall_run(stall_run), .wdog_trip(wdog_trip), .conflict(conflict)
  );

  pipe_stage_reg #(.DATA_W(8), .CNT_W(3), .STALL_LIMIT(7), .CLEAR_ON_BUB(1'b0)) u_sat (
    .clk(clk), .reset(s_reset), .stall(s_stall), .bubble(s_bubble),
    .in_stat(s_in_stat), .in_icode(s_in_icode), .in_data(s_in_data),
    .out_stat(s_out_stat), .out_icode(s_out_icode), .out_data(s_out_data),
    .out_valid(s_out_valid), .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt),
    .stall_run(s_stall_run), .wdog_trip(s_wdog_trip), .conflict(s_conflict)
  );

  typedef struct {
    logic         rst, stl, bub;
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [143:0] data;
    logic [2:0]   e_stat;
    logic [3:0]   e_icode;
    logic [143:0] e_data;
    logic         e_valid;
    logic [15:0]  e_scnt, e_bcnt, e_run;
    logic         e_wdog, e_conf;
  } vec_t;

  localparam logic [143:0] ONES = {144{1'b1}};
  vec_t vecs[12];

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic b,
                       input logic [3:0] icode, input logic [143:0] data);
    reset = r; stall = s; bubble = b; in_stat = 3'd0; in_icode = icode; in_data = data;
  endtask

  task automatic check_main(input string tag, input logic [3:0] e_icode, input logic e_valid,
                            input logic [15:0] e_scnt, input logic [15:0] e_bcnt,
                            input logic [15:0] e_run, input logic e_wdog, input logic e_conf);
    check({tag, ".icode"}, 144'(out_icode), 144'(e_icode));
    check({tag, ".valid"}, 144'(out_valid), 144'(e_valid));
    check({tag, ".stall_cnt"}, 144'(stall_cnt), 144'(e_scnt));
    check({tag, ".bubble_cnt"}, 144'(bubble_cnt), 144'(e_bcnt));
    check({tag, ".stall_run"}, 144'(stall_run), 144'(e_run));
    check({tag, ".wdog"}, 144'(wdog_trip), 144'(e_wdog));
    check({tag, ".conflict"}, 144'(conflict), 144'(e_conf));
  endtask

  initial begin
    //          rst   stl   bub   stat icode data        e_stat e_icode e_data   v   scnt bcnt run w  c
    vecs[0]  = '{1'b1, 1'bx, 1'bx, 3'd0, 4'h6, 144'h66, 3'd1, 4'h1, 144'h0,  1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'bx, 3'd0, 4'h6, 144'h66, 3'd1, 4'h1, 144'h0,  1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h6, 144'h66, 3'd0, 4'h6, 144'h66, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h7, 144'h77, 3'd0, 4'h7, 144'h77, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h8, 144'h88, 3'd0, 4'h8, 144'h88, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h5, 144'h55, 3'd0, 4'h5, 144'h55, 1'b1, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 4'h2, 144'h22, 3'd0, 4'h5, 144'h55, 1'b1, 16'd1, 16'd0, 16'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd0, 4'h2, 144'h22, 3'd0, 4'h5, 144'h55, 1'b1, 16'd2, 16'd0, 16'd2, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 4'h2, 144'h22, 3'd0, 4'h5, 144'h55, 1'b1, 16'd3, 16'd0, 16'd3, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'd0, 4'h2, 144'h22, 3'd0, 4'h2, 144'h22, 1'b1, 16'd3, 16'd0, 16'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 3'd0, 4'h3, ONES,    3'd1, 4'h1, 144'h0,  1'b0, 16'd3, 16'd1, 16'd0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 3'd2, 4'h4, ONES,    3'd2, 4'h4, ONES,    1'b1, 16'd3, 16'd1, 16'd0, 1'b0, 1'b0};

    s_reset = 1'b1; s_stall = 1'b0; s_bubble = 1'b0;
    s_in_stat = 3'd0; s_in_icode = 4'h0; s_in_data = 8'h0;

    for (int i = 0; i < 12; i++) begin
      reset = vecs[i].rst; stall = vecs[i].stl; bubble = vecs[i].bub;
      in_stat = vecs[i].stat; in_icode = vecs[i].icode; in_data = vecs[i].data;
      step();
      check($sformatf("v%0d.stat", i), 144'(out_stat), 144'(vecs[i].e_stat));
      check($sformatf("v%0d.data", i), out_data, vecs[i].e_data);
      check_main($sformatf("v%0d", i), vecs[i].e_icode, vecs[i].e_valid, vecs[i].e_scnt,
                 vecs[i].e_bcnt, vecs[i].e_run, vecs[i].e_wdog, vecs[i].e_conf);
    end

    // Watchdog: 7 stalls leave it clear, the 8th trips it, and it stays set.
    for (int i = 1; i <= 7; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'h9, 144'h99);
      step();
      check_main($sformatf("wd%0d", i), 4'h4, 1'b1, 16'(3 + i), 16'd1, 16'(i), 1'b0, 1'b0);
    end
    step();
    check_main("wd8", 4'h4, 1'b1, 16'd11, 16'd1, 16'd8, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 4'h9, 144'h99);
    step();
    check_main("wd_release", 4'h9, 1'b1, 16'd11, 16'd1, 16'd0, 1'b1, 1'b0);

    // Conflict: stall wins over bubble, flag is sticky until reset.
    drive(1'b0, 1'b0, 1'b0, 4'h5, 144'h55);
    step();
    drive(1'b0, 1'b1, 1'b1, 4'h3, 144'h33);
    step();
    check_main("conf", 4'h5, 1'b1, 16'd12, 16'd1, 16'd1, 1'b1, 1'b1);
    check("conf.data", out_data, 144'h55);
    drive(1'b0, 1'b0, 1'b0, 4'h6, 144'h66);
    step();
    check_main("conf_hold", 4'h6, 1'b1, 16'd12, 16'd1, 16'd0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 4'h6, 144'h66);
    step();
    check_main("conf_rst", 4'h1, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
    check("conf_rst.data", out_data, 144'h0);

    // Saturation on the 3-bit-counter instance, with payload kept on bubble.
    step();
    s_reset = 1'b0; s_in_icode = 4'h6; s_in_data = 8'hA5;
    step();
    s_bubble = 1'b1; s_in_icode = 4'h3; s_in_data = 8'h3C;
    for (int i = 0; i < 10; i++) step();
    check("sat.bubble_cnt", 144'(s_bubble_cnt), 144'd7);
    check("sat.bub_data", 144'(s_out_data), 144'hA5);
    check("sat.bub_icode", 144'(s_out_icode), 144'h1);
    check("sat.bub_valid", 144'(s_out_valid), 144'd0);
    s_bubble = 1'b0; s_stall = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("sat.wdog6", 144'(s_wdog_trip), 144'd0);
    step();
    check("sat.wdog7", 144'(s_wdog_trip), 144'd1);
    for (int i = 0; i < 3; i++) step();
    check("sat.stall_cnt", 144'(s_stall_cnt), 144'd7);
    check("sat.stall_run", 144'(s_stall_run), 144'd7);
    check("sat.wdog_hold", 144'(s_wdog_trip), 144'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
